// File: rtl/lsu_port_arbiter.sv
// Two-port (core/host) arbiter in front of a single non-pipelined LSU port.
// One access is in flight at a time; grants are issued only from IDLE.
module lsu_port_arbiter #(
  parameter int unsigned HOST_MAX_BURST = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_bmask_i,
  input  logic        core_signed_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_wdata_i,
  input  logic [3:0]  host_bmask_i,
  input  logic        host_signed_i,
  input  logic        host_lock_i,
  output logic        core_gnt_o,
  output logic        host_gnt_o,
  output logic        core_rvalid_o,
  output logic        host_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_wr_data_o,
  output logic [3:0]  lsu_bytemask_o,
  output logic        lsu_signed_o,
  output logic        lsu_write_o,
  output logic        lsu_read_o,
  input  logic [31:0] load_rdata_i,
  input  logic        illegal_access_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] MAX_B = 4'(HOST_MAX_BURST);

  state_t      r_state;
  logic        r_owner_host;
  logic        r_last_host;
  logic [3:0]  r_burst_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_bmask;
  logic        r_signed;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_rvalid_core;
  logic        r_rvalid_host;

  logic w_pick_host;
  logic w_accept;
  logic w_active;

  // Burst limit beats the lock; lock beats round-robin.
  always_comb begin
    w_pick_host = 1'b0;
    if (host_req_i && !core_req_i) begin
      w_pick_host = 1'b1;
    end else if (host_req_i && core_req_i) begin
      if (r_burst_cnt == MAX_B) w_pick_host = 1'b0;
      else if (host_lock_i)     w_pick_host = 1'b1;
      else                      w_pick_host = !r_last_host;
    end
  end

  // Gating with rst_n_i keeps grants low while reset is asserted.
  assign w_accept   = rst_n_i && (r_state == IDLE) && (core_req_i || host_req_i);
  assign core_gnt_o = w_accept && !w_pick_host;
  assign host_gnt_o = w_accept && w_pick_host;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_owner_host  <= 1'b0;
      r_last_host   <= 1'b1;
      r_burst_cnt   <= 4'd0;
      r_we          <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_bmask       <= 4'd0;
      r_signed      <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= 32'd0;
      r_rvalid_core <= 1'b0;
      r_rvalid_host <= 1'b0;
    end else begin
      r_rvalid_core <= 1'b0;
      r_rvalid_host <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner_host <= w_pick_host;
            r_last_host  <= w_pick_host;
            r_we         <= w_pick_host ? host_we_i     : core_we_i;
            r_addr       <= w_pick_host ? host_addr_i   : core_addr_i;
            r_wdata      <= w_pick_host ? host_wdata_i  : core_wdata_i;
            r_bmask      <= w_pick_host ? host_bmask_i  : core_bmask_i;
            r_signed     <= w_pick_host ? host_signed_i : core_signed_i;
            if (!w_pick_host)
              r_burst_cnt <= 4'd0;
            else if (core_req_i && (r_burst_cnt < MAX_B))
              r_burst_cnt <= r_burst_cnt + 4'd1;
            r_state <= ACC;
          end
        end
        ACC: begin
          r_err   <= illegal_access_i;
          r_state <= HOLD;
        end
        HOLD: r_state <= r_we ? IDLE : RESP;
        RESP: begin
          r_rdata       <= load_rdata_i;
          r_rvalid_core <= !r_owner_host;
          r_rvalid_host <= r_owner_host;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_active       = (r_state == ACC) || (r_state == HOLD);
  assign lsu_addr_o     = w_active ? r_addr  : 32'd0;
  assign lsu_wr_data_o  = w_active ? r_wdata : 32'd0;
  assign lsu_bytemask_o = w_active ? r_bmask : 4'd0;
  assign lsu_signed_o   = w_active && r_signed;
  assign lsu_write_o    = w_active && r_we;
  assign lsu_read_o     = w_active && !r_we;

  assign core_rvalid_o = r_rvalid_core;
  assign host_rvalid_o = r_rvalid_host;
  assign rdata_o       = r_rdata;
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

endmodule
